// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Architectural register file with rename tracking. It has
//            NUM_RD read ports and NUM_CM commit ports, and it forwards
//            same-cycle commits to the read ports. When REGFILE_CKPT_EN is
//            defined, the rename table also gets a branch checkpoint.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int ROB_WIDTH = 4,
  parameter int NUM_RD    = 2,
  parameter int NUM_CM    = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear,
  input  logic [NUM_CM-1:0]         commit_ready,
  input  logic [NUM_CM*5-1:0]       commit_reg_id,
  input  logic [NUM_CM*XLEN-1:0]    commit_val,
  input  logic [NUM_CM*ROB_WIDTH-1:0] commit_rob_id,
  output logic [NUM_RD*ROB_WIDTH-1:0] search_rob_id,
  input  logic [NUM_RD-1:0]         search_ready,
  input  logic [NUM_RD*XLEN-1:0]    search_val,
  input  logic                      issue_reg_ready,
  input  logic [4:0]                issue_reg_rd,
  input  logic [ROB_WIDTH-1:0]      issue_rob_id,
  input  logic [NUM_RD*5-1:0]       get_reg,
  output logic [NUM_RD*XLEN-1:0]    get_val,
  output logic [NUM_RD-1:0]         has_dep,
  output logic [NUM_RD*ROB_WIDTH-1:0] get_dep,
  input  logic                      ckpt_save,
  input  logic                      ckpt_restore,
  output logic                      ckpt_valid
);

  localparam int c_NREG = 32;

  logic [XLEN-1:0]      r_val  [c_NREG];
  logic [ROB_WIDTH-1:0] r_dep  [c_NREG];
  logic [c_NREG-1:0]    r_busy;

  logic [ROB_WIDTH-1:0] w_dep_nxt [c_NREG];
  logic [c_NREG-1:0]    w_busy_nxt;
  logic                 w_do_clear;

  // Commit releases first, then the issue rename lands on top of them.
  always_comb begin
    w_busy_nxt = r_busy;
    w_dep_nxt  = r_dep;
    for (int k = 0; k < NUM_CM; k++) begin
      if (commit_ready[k] && r_busy[commit_reg_id[k*5 +: 5]] &&
          r_dep[commit_reg_id[k*5 +: 5]] == commit_rob_id[k*ROB_WIDTH +: ROB_WIDTH])
        w_busy_nxt[commit_reg_id[k*5 +: 5]] = 1'b0;
    end
    if (issue_reg_ready && issue_reg_rd != 5'd0) begin
      w_busy_nxt[issue_reg_rd] = 1'b1;
      w_dep_nxt[issue_reg_rd]  = issue_rob_id;
    end
  end

`ifdef REGFILE_CKPT_EN
  logic [ROB_WIDTH-1:0] r_snap_dep [c_NREG];
  logic [c_NREG-1:0]    r_snap_busy;
  logic [c_NREG-1:0]    w_snap_busy_rel;
  logic                 r_ckpt_valid;
  logic                 w_do_restore;

  always_comb begin
    w_snap_busy_rel = r_snap_busy;
    for (int k = 0; k < NUM_CM; k++) begin
      if (commit_ready[k] && r_snap_busy[commit_reg_id[k*5 +: 5]] &&
          r_snap_dep[commit_reg_id[k*5 +: 5]] == commit_rob_id[k*ROB_WIDTH +: ROB_WIDTH])
        w_snap_busy_rel[commit_reg_id[k*5 +: 5]] = 1'b0;
    end
  end

  assign w_do_clear   = clear | (ckpt_restore & ~r_ckpt_valid);
  assign w_do_restore = ~clear & ckpt_restore & r_ckpt_valid;
  assign ckpt_valid   = r_ckpt_valid;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_snap_busy  <= '0;
      r_ckpt_valid <= 1'b0;
      for (int i = 0; i < c_NREG; i++) r_snap_dep[i] <= '0;
    end else if (rdy_in) begin
      if (w_do_clear || w_do_restore) begin
        r_ckpt_valid <= 1'b0;
      end else if (ckpt_save) begin
        r_snap_busy  <= w_busy_nxt;
        r_snap_dep   <= w_dep_nxt;
        r_ckpt_valid <= 1'b1;
      end else if (r_ckpt_valid) begin
        r_snap_busy  <= w_snap_busy_rel;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused   = ckpt_save;
  assign w_do_clear = clear | ckpt_restore;
  assign ckpt_valid = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy <= '0;
      for (int i = 0; i < c_NREG; i++) begin
        r_val[i] <= '0;
        r_dep[i] <= '0;
      end
    end else if (rdy_in) begin
      // Ascending order so the highest-index port wins on a shared register.
      for (int k = 0; k < NUM_CM; k++) begin
        if (commit_ready[k] && commit_reg_id[k*5 +: 5] != 5'd0)
          r_val[commit_reg_id[k*5 +: 5]] <= commit_val[k*XLEN +: XLEN];
      end
      if (w_do_clear) begin
        r_busy <= '0;
        for (int i = 0; i < c_NREG; i++) r_dep[i] <= '0;
      end
`ifdef REGFILE_CKPT_EN
      else if (w_do_restore) begin
        r_busy <= w_snap_busy_rel;
        r_dep  <= r_snap_dep;
      end
`endif
      else begin
        r_busy <= w_busy_nxt;
        r_dep  <= w_dep_nxt;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [4:0]           w_reg;
    logic [ROB_WIDTH-1:0] w_rdep;
    logic                 w_hit;
    logic [XLEN-1:0]      w_hit_val;
    logic [XLEN-1:0]      w_val;

    assign w_reg  = get_reg[p*5 +: 5];
    assign w_rdep = r_dep[w_reg];

    always_comb begin
      w_hit     = 1'b0;
      w_hit_val = '0;
      for (int k = 0; k < NUM_CM; k++) begin
        if (commit_ready[k] && commit_rob_id[k*ROB_WIDTH +: ROB_WIDTH] == w_rdep) begin
          w_hit     = 1'b1;
          w_hit_val = commit_val[k*XLEN +: XLEN];
        end
      end
      if (!r_busy[w_reg])      w_val = r_val[w_reg];
      else if (w_hit)          w_val = w_hit_val;
      else if (search_ready[p]) w_val = search_val[p*XLEN +: XLEN];
      else                     w_val = '0;
    end

    assign get_val[p*XLEN +: XLEN]            = w_val;
    assign get_dep[p*ROB_WIDTH +: ROB_WIDTH]  = w_rdep;
    assign search_rob_id[p*ROB_WIDTH +: ROB_WIDTH] = w_rdep;
    assign has_dep[p] = r_busy[w_reg] & ~w_hit & ~search_ready[p];
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Directed self-checking bench for regfile_mp, with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int RW   = 4;
`ifdef REGFILE_CKPT_EN
  localparam bit c_CKPT = 1'b1;
`else
  localparam bit c_CKPT = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear;
  logic [1:0]    commit_ready;
  logic [9:0]    commit_reg_id;
  logic [63:0]   commit_val;
  logic [7:0]    commit_rob_id;
  logic [7:0]    search_rob_id;
  logic [1:0]    search_ready;
  logic [63:0]   search_val;
  logic          issue_reg_ready;
  logic [4:0]    issue_reg_rd;
  logic [RW-1:0] issue_rob_id;
  logic [9:0]    get_reg;
  logic [63:0]   get_val;
  logic [1:0]    has_dep;
  logic [7:0]    get_dep;
  logic          ckpt_save, ckpt_restore, ckpt_valid;

  int n_vec = 0;
  int n_err = 0;

  regfile_mp #(.XLEN(XLEN), .ROB_WIDTH(RW), .NUM_RD(2), .NUM_CM(2)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .commit_ready(commit_ready), .commit_reg_id(commit_reg_id),
    .commit_val(commit_val), .commit_rob_id(commit_rob_id),
    .search_rob_id(search_rob_id), .search_ready(search_ready),
    .search_val(search_val), .issue_reg_ready(issue_reg_ready),
    .issue_reg_rd(issue_reg_rd), .issue_rob_id(issue_rob_id),
    .get_reg(get_reg), .get_val(get_val), .has_dep(has_dep),
    .get_dep(get_dep), .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
    .ckpt_valid(ckpt_valid)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [RW-1:0] rob);
    issue_reg_ready = 1'b1; issue_reg_rd = rd; issue_rob_id = rob;
    tick();
    issue_reg_ready = 1'b0;
  endtask

  task automatic read0(input logic [4:0] r);
    get_reg[4:0] = r;
    #1;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    commit_ready = '0; commit_reg_id = '0; commit_val = '0; commit_rob_id = '0;
    search_ready = '0; search_val = '0;
    issue_reg_ready = 1'b0; issue_reg_rd = '0; issue_rob_id = '0;
    get_reg = '0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
    tick(); tick();
    get_reg = {5'd5, 5'd5}; #1;
    check_vec("rst_get_val", get_val, 64'h0);
    check_vec("rst_has_dep", {62'h0, has_dep}, 64'h0);
    check_vec("rst_get_dep", {56'h0, get_dep}, 64'h0);
    check_vec("rst_search", {56'h0, search_rob_id}, 64'h0);
    check_vec("rst_ckpt_valid", {63'h0, ckpt_valid}, 64'h0);
    rst_in = 1'b1;
    tick();

    // 1: rename x5 -> rob 3
    get_reg = {5'd0, 5'd0};
    issue(5'd5, 4'd3);
    read0(5'd5);
    check_vec("t1_has_dep", {63'h0, has_dep[0]}, 64'h1);
    check_vec("t1_get_dep", {60'h0, get_dep[3:0]}, 64'h3);
    check_vec("t1_search_id", {60'h0, search_rob_id[3:0]}, 64'h3);
    check_vec("t1_get_val", {32'h0, get_val[31:0]}, 64'h0);
    check_vec("t1_x0_port1", {31'h0, has_dep[1], get_val[63:32]}, 64'h0);
    search_ready = 2'b01; search_val[31:0] = 32'h1234; #1;
    check_vec("t1_search_val", {31'h0, has_dep[0], get_val[31:0]}, 64'h1234);
    search_ready = 2'b00; #1;

    // 2: commit port 1 resolves x5 with forwarding
    commit_ready = 2'b10; commit_reg_id = {5'd5, 5'd0};
    commit_val = {32'hDEAD, 32'h0}; commit_rob_id = {4'd3, 4'd0}; #1;
    check_vec("t2_fwd", {31'h0, has_dep[0], get_val[31:0]}, 64'hDEAD);
    tick();
    commit_ready = 2'b00; #1;
    check_vec("t2_after", {31'h0, has_dep[0], get_val[31:0]}, 64'hDEAD);

    // 3: same-reg commits, highest port wins; issue beats stale release
    commit_ready = 2'b11; commit_reg_id = {5'd7, 5'd7};
    commit_val = {32'h22, 32'h11}; commit_rob_id = {4'd1, 4'd0};
    tick();
    commit_ready = 2'b00;
    read0(5'd7);
    check_vec("t3_wide_commit", {31'h0, has_dep[0], get_val[31:0]}, 64'h22);
    issue(5'd7, 4'd4);
    commit_ready = 2'b01; commit_reg_id = {5'd0, 5'd7};
    commit_val = {32'h0, 32'h33}; commit_rob_id = {4'd0, 4'd4};
    issue(5'd7, 4'd9);
    commit_ready = 2'b00; #1;
    check_vec("t3_issue_wins", {59'h0, has_dep[0], get_dep[3:0]}, {59'h0, 1'b1, 4'd9});
    commit_ready = 2'b11; commit_rob_id = {4'd9, 4'd9};
    commit_val = {32'hBB, 32'hAA}; #1;
    check_vec("t3_hit_prio", {31'h0, has_dep[0], get_val[31:0]}, 64'hBB);
    commit_ready = 2'b00; #1;

    // 4: checkpoint and restore
    issue(5'd10, 4'd2);
    ckpt_save = 1'b1; tick(); ckpt_save = 1'b0;
    check_vec("t4_ckpt_valid", {63'h0, ckpt_valid}, {63'h0, c_CKPT});
    issue(5'd10, 4'd5);
    read0(5'd10);
    check_vec("t4_rename2", {59'h0, has_dep[0], get_dep[3:0]}, {59'h0, 1'b1, 4'd5});
    commit_ready = 2'b01; commit_reg_id = {5'd0, 5'd10};
    commit_val = {32'h0, 32'hAB}; commit_rob_id = {4'd0, 4'd2};
    tick();
    commit_ready = 2'b00; #1;
    check_vec("t4_still_dep", {63'h0, has_dep[0]}, 64'h1);
    ckpt_restore = 1'b1; tick(); ckpt_restore = 1'b0; #1;
    check_vec("t4_restore_x10", {31'h0, has_dep[0], get_val[31:0]}, 64'hAB);
    check_vec("t4_ckpt_cleared", {63'h0, ckpt_valid}, 64'h0);
    read0(5'd7);
    check_vec("t4_restore_x7", {63'h0, has_dep[0]}, {63'h0, c_CKPT});

    // 5: clear beats issue; rdy_in low freezes state
    issue(5'd12, 4'd6);
    clear = 1'b1;
    issue(5'd3, 4'd1);
    clear = 1'b0;
    get_reg = {5'd12, 5'd3}; #1;
    check_vec("t5_clear", {62'h0, has_dep}, 64'h0);
    check_vec("t5_clear_dep", {60'h0, get_dep[3:0]}, 64'h0);
    rdy_in = 1'b0;
    commit_ready = 2'b01; commit_reg_id = {5'd0, 5'd5};
    commit_val = {32'h0, 32'h55}; commit_rob_id = '0;
    issue(5'd3, 4'd7);
    commit_ready = 2'b00; rdy_in = 1'b1;
    get_reg = {5'd5, 5'd3}; #1;
    check_vec("t5_hold_dep", {63'h0, has_dep[0]}, 64'h0);
    check_vec("t5_hold_val", {32'h0, get_val[63:32]}, 64'hDEAD);

    // 6: asynchronous reset mid-cycle
    issue(5'd9, 4'd8);
    ckpt_save = 1'b1; tick(); ckpt_save = 1'b0;
    get_reg = {5'd5, 5'd9}; #1;
    check_vec("t6_pre", {63'h0, has_dep[0]}, 64'h1);
    check_vec("t6_pre_ckpt", {63'h0, ckpt_valid}, {63'h0, c_CKPT});
    #1 rst_in = 1'b0;
    #1;
    check_vec("t6_rst_dep", {54'h0, ckpt_valid, has_dep, get_dep}, 64'h0);
    check_vec("t6_rst_val", get_val, 64'h0);
    tick();
    rst_in = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
